lsu_mem_bridge: RTL

- Clocked data-memory bridge directly downstream of the load/store request splitter.
- Accepts the splitter's two 4-phase bundled-data channels (load, store) and synchronises the requests into the clock domain. Performs one access on a synchronous single-port data memory, then returns 4-phase acknowledges that the splitter merges into its upstream ack.
- Handles byte lanes, load sign/zero extension and misalignment detection.

---
 rtl/lsu_mem_bridge.sv | 119 +++++++++++
 1 files changed

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: synchronises 4-phase load/store requests and performs one single-port data memory access per handshake
module lsu_mem_bridge #(
  parameter int ADDR_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  output logic              ld_ack,
  input  logic              st_req,
  output logic              st_ack,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              access_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, ACK} state_e;
  state_e                 state_q;
  logic [SYNC_STAGES-1:0] ld_sync_q, st_sync_q;
  logic                   st_op_q;
  logic [2:0]             f3_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [31:0]            wdata_q;
  logic                   ld_s, st_s, is_h, is_w, illegal, err_d;
  logic [3:0]             be_d;
  logic [15:0]            lane;
  logic [31:0]            wdata_d, rdata_d;
  always_comb begin
    ld_s    = ld_sync_q[SYNC_STAGES-1];
    st_s    = st_sync_q[SYNC_STAGES-1];
    is_h    = f3_q[1:0] == 2'b01;
    is_w    = f3_q[1:0] == 2'b10;
    illegal = st_op_q ? (f3_q[2] | (f3_q[1:0] == 2'b11)) : ((f3_q == 3'b011) | (f3_q[2:1] == 2'b11));
    err_d   = illegal | (is_h & addr_q[0]) | (is_w & (|addr_q[1:0]));
    be_d    = is_w ? 4'b1111 : is_h ? (4'b0011 << {addr_q[1], 1'b0}) : (4'b0001 << addr_q[1:0]);
    wdata_d = is_w ? wdata_q : is_h ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    lane    = 16'(mem_rdata >> {addr_q[1:0], 3'b000});
    rdata_d = is_w ? mem_rdata
            : is_h ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]}
            : {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_sync_q <= '0;
      st_sync_q <= '0;
    end else begin
      ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], ld_req};
      st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], st_req};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      st_op_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_ack     <= 1'b0;
      st_ack     <= 1'b0;
      rdata      <= '0;
      access_err <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_q)
        IDLE: if (ld_s | st_s) begin
          f3_q    <= funct3;
          addr_q  <= addr;
          wdata_q <= wdata;
          st_op_q <= ~ld_s;
          state_q <= CHECK;
        end
        CHECK: if (err_d) begin
          access_err <= 1'b1;
          if (!st_op_q) rdata <= '0;
          ld_ack     <= ~st_op_q;
          st_ack     <= st_op_q;
          state_q    <= ACK;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= st_op_q;
          mem_be    <= be_d;
          mem_addr  <= {addr_q[ADDR_W-1:2], 2'b00};
          mem_wdata <= wdata_d;
          state_q   <= ISSUE;
        end
        ISSUE, WAIT: begin
          mem_en <= 1'b0;
          if (mem_ready) begin
            if (!st_op_q) rdata <= rdata_d;
            ld_ack  <= ~st_op_q;
            st_ack  <= st_op_q;
            state_q <= ACK;
          end else begin
            state_q <= WAIT;
          end
        end
        ACK: if (!(st_op_q ? st_s : ld_s)) begin
          ld_ack     <= 1'b0;
          st_ack     <= 1'b0;
          access_err <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
